aes_key_expand_seq: RTL and testbench

- Iterative AES key expansion (FIPS-197 5.2), one 32-bit schedule word per clock.
- Sits directly upstream of the pipelined AES inverse cipher. It drives that cipher's k_sch[0:Nr] array and a ready flag that gates the cipher's load input.
- Supports AES-128, AES-192 and AES-256 through the Nk parameter.
- Trades latency (40–52 cycles per new key) for area: a single SubWord instance instead of Nr unrolled stages.

---
 rtl/aes_key_expand_seq_pkg.sv | 63 ++++++
 rtl/aes_key_word_gen.sv | 32 +++
 rtl/aes_key_expand_seq.sv | 145 ++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_expand_seq_pkg.sv
// Shared AES helpers for the iterative key expander: S-box, SubWord,
// RotWord, xtime, the round-constant seed and small enumerations.
package aes_key_expand_seq_pkg;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2
  } key_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } kx_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] a_sh;
    p    = 8'h00;
    a_sh = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        p = p ^ a_sh;
      end else begin
        p = p;
      end
      a_sh = xtime(a_sh);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (b^254, zero maps to zero) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational next-schedule-word generator. A single SubWord instance is
// shared between the rotated (i mod Nk == 0) and plain (i mod 8 == 4) paths.
module aes_key_word_gen
  import aes_key_expand_seq_pkg::*;
(
  input  logic [31:0] w_prev_i,
  input  logic [31:0] w_nk_i,
  input  logic [7:0]  rcon_i,
  input  logic        mod0_i,
  input  logic        mod4_i,
  output logic [31:0] w_new_o
);

  logic [31:0] sw_in_d;
  logic [31:0] sw_out_d;
  logic [31:0] temp_d;

  // Select SubWord input, apply it once, then pick the temp word for this step.
  always_comb begin
    sw_in_d  = mod0_i ? rot_word(w_prev_i) : w_prev_i;
    sw_out_d = sub_word(sw_in_d);
    if (mod0_i) begin
      temp_d = sw_out_d ^ {rcon_i, 24'h000000};
    end else if (mod4_i) begin
      temp_d = sw_out_d;
    end else begin
      temp_d = w_prev_i;
    end
    w_new_o = w_nk_i ^ temp_d;
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key expansion: produces one 32-bit schedule word per clock
// and presents the full round-key array with a ready flag for the
// downstream inverse cipher.
module aes_key_expand_seq
  import aes_key_expand_seq_pkg::*;
#(
  parameter int Nk = 4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_load,
  input  logic [32*Nk-1:0]  key,
  output logic [127:0]      k_sch [0:Nk+6],
  output logic              busy,
  output logic              ready
);

  localparam int Nr = Nk + 6;
  localparam int NW = 4 * (Nr + 1);

  generate
    if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_nk_check
      $error("aes_key_expand_seq: Nk must be 4, 6 or 8");
    end
  endgenerate

  kx_state_e   state_q, state_d;
  logic [31:0] w_q [0:NW-1];
  logic [31:0] w_d [0:NW-1];
  logic [5:0]  i_q, i_d;
  logic [2:0]  imod_q, imod_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic [5:0]  idx_prev_d;
  logic [5:0]  idx_nk_d;
  logic [31:0] w_prev_d;
  logic [31:0] w_nk_d;
  logic [31:0] w_new_d;
  logic        mod0_d;
  logic        mod4_d;

  // Operand fetch for the word generator; indices are clamped so IDLE/DONE
  // never address outside the register file.
  always_comb begin
    idx_prev_d = (i_q != 6'd0) ? (i_q - 6'd1) : 6'd0;
    idx_nk_d   = (i_q >= 6'(Nk)) ? (i_q - 6'(Nk)) : 6'd0;
    w_prev_d   = w_q[idx_prev_d];
    w_nk_d     = w_q[idx_nk_d];
    mod0_d     = (imod_q == 3'd0);
    mod4_d     = (Nk == 8) && (imod_q == 3'd4);
  end

  aes_key_word_gen u_word_gen (
    .w_prev_i (w_prev_d),
    .w_nk_i   (w_nk_d),
    .rcon_i   (rcon_q),
    .mod0_i   (mod0_d),
    .mod4_i   (mod4_d),
    .w_new_o  (w_new_d)
  );

  // Next-state, index/rcon update and word-file write selection.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    imod_d  = imod_q;
    rcon_d  = rcon_q;
    w_d     = w_q;
    if (key_load) begin
      // A new key restarts from any state; upper words become stale.
      for (int j = 0; j < Nk; j++) begin
        w_d[j] = key[32*(Nk-1-j) +: 32];
      end
      i_d     = 6'(Nk);
      imod_d  = 3'd0;
      rcon_d  = RCON_INIT;
      state_d = ST_EXPAND;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_EXPAND: begin
          w_d[i_q] = w_new_d;
          i_d      = i_q + 6'd1;
          imod_d   = (imod_q == 3'(Nk-1)) ? 3'd0 : (imod_q + 3'd1);
          rcon_d   = mod0_d ? xtime(rcon_q) : rcon_q;
          if (i_q == 6'(NW-1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXPAND;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // Flags trail the state by one cycle, so ready rises the cycle after the
    // last word is written and drops immediately on a new key.
    busy_d  = key_load | (state_q == ST_EXPAND);
    ready_d = ~key_load & (state_q == ST_DONE);
  end

  // State, counters, flags and word file with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= 6'd0;
      imod_q  <= 3'd0;
      rcon_q  <= 8'h00;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      for (int j = 0; j < NW; j++) begin
        w_q[j] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      imod_q  <= imod_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      for (int j = 0; j < NW; j++) begin
        w_q[j] <= w_d[j];
      end
    end
  end

  generate
    for (genvar r = 0; r <= Nr; r++) begin : g_ksch
      assign k_sch[r] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
    end
  endgenerate

  assign busy  = busy_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: one instance per key size,
// FIPS-197 vectors plus random keys against a textbook reference model.
module tb_aes_key_expand_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         ld4, ld6, ld8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [127:0] ks4 [0:10];
  logic [127:0] ks6 [0:12];
  logic [127:0] ks8 [0:14];
  logic         busy4, busy6, busy8;
  logic         ready4, ready6, ready8;

  int errors = 0;
  int checks = 0;

  logic [7:0]  sbox_t [0:255];
  logic [31:0] exp_w [0:59];
  logic [7:0]  rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_key_expand_seq #(.Nk(4)) dut4 (.clk(clk), .rst(rst), .key_load(ld4), .key(key4),
                                     .k_sch(ks4), .busy(busy4), .ready(ready4));
  aes_key_expand_seq #(.Nk(6)) dut6 (.clk(clk), .rst(rst), .key_load(ld6), .key(key6),
                                     .k_sch(ks6), .busy(busy6), .ready(ready6));
  aes_key_expand_seq #(.Nk(8)) dut8 (.clk(clk), .rst(rst), .key_load(ld8), .key(key8),
                                     .k_sch(ks8), .busy(busy8), .ready(ready8));

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    logic [14:0] aw;
    logic [14:0] poly;
    p    = 15'h0;
    aw   = {7'h0, a};
    poly = 15'h11b;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (aw << i);
    for (int bt = 14; bt >= 8; bt--)
      if (p[bt]) p = p ^ (poly << (bt - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] m_sub(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic compute_model(input logic [255:0] k, input int nk);
    logic [31:0] t;
    int total;
    total = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) exp_w[i] = k[32*(nk-1-i) +: 32];
    for (int i = nk; i < total; i++) begin
      t = exp_w[i-1];
      if (i % nk == 0)
        t = m_sub({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
      else if (nk > 6 && i % nk == 4)
        t = m_sub(t);
      exp_w[i] = exp_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    return {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
  endfunction

  // ---------------- DUT access / stimulus helpers ----------------
  function automatic logic [127:0] ks_of(input int nk, input int r);
    if (nk == 4) return ks4[r];
    else if (nk == 6) return ks6[r];
    else return ks8[r];
  endfunction

  function automatic logic ready_of(input int nk);
    return (nk == 4) ? ready4 : (nk == 6) ? ready6 : ready8;
  endfunction

  function automatic logic busy_of(input int nk);
    return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int nk, input logic [255:0] k);
    if (nk == 4) begin key4 = k[127:0]; ld4 = 1'b1; end
    else if (nk == 6) begin key6 = k[191:0]; ld6 = 1'b1; end
    else begin key8 = k; ld8 = 1'b1; end
    tick();
    ld4 = 1'b0; ld6 = 1'b0; ld8 = 1'b0;
  endtask

  task automatic wait_ready(input int nk, output int n);
    n = 0;
    while (ready_of(nk) !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int q = 0; q < 8; q++) k[32*q +: 32] = $urandom;
    return k;
  endfunction

  // Compare the whole schedule of one instance against exp_w.
  task automatic check_schedule(input int nk, input string tag);
    for (int r = 0; r <= nk + 6; r++) begin
      checks++;
      if (ks_of(nk, r) !== exp_rk(r)) begin
        errors++;
        $display("FAIL %s nk=%0d k_sch[%0d]: got %h expected %h", tag, nk, r, ks_of(nk, r), exp_rk(r));
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic nz;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int nk = 4; nk <= 8; nk += 2) begin
      nz = 1'b0;
      for (int r = 0; r <= nk + 6; r++) if (ks_of(nk, r) !== 128'h0) nz = 1'b1;
      checks++;
      if (busy_of(nk) !== 1'b0 || ready_of(nk) !== 1'b0 || nz !== 1'b0) begin
        errors++;
        $display("FAIL reset nk=%0d: busy=%b ready=%b nonzero=%b expected 0 0 0",
                 nk, busy_of(nk), ready_of(nk), nz);
      end
    end
  endtask

  task automatic test_fips_vectors();
    int n;
    logic [255:0] k;
    logic [127:0] got;
    // AES-128
    k = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    load(4, k);
    checks++;
    if (busy4 !== 1'b1 || ready4 !== 1'b0) begin
      errors++; $display("FAIL fips128 start: busy=%b ready=%b expected 1 0", busy4, ready4);
    end
    wait_ready(4, n);
    checks++;
    if (n != 41) begin errors++; $display("FAIL fips128 latency: got %0d expected 41", n); end
    got = ks4[1];
    checks++;
    if (got[127:96] !== 32'ha0fafe17) begin
      errors++; $display("FAIL fips128 w4: got %h expected a0fafe17", got[127:96]);
    end
    checks++;
    if (ks4[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL fips128 k_sch10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", ks4[10]);
    end
    checks++;
    if (ks4[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      errors++; $display("FAIL fips128 k_sch0: got %h expected key", ks4[0]);
    end
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL fips128 busy at done: got %b expected 0", busy4); end
    // AES-192
    k = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
    load(6, k);
    wait_ready(6, n);
    checks++;
    if (n != 47) begin errors++; $display("FAIL fips192 latency: got %0d expected 47", n); end
    checks++;
    if (ks6[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
      errors++; $display("FAIL fips192 k_sch12: got %h expected e98ba06f448c773c8ecc720401002202", ks6[12]);
    end
    // AES-256
    k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    load(8, k);
    wait_ready(8, n);
    checks++;
    if (n != 53) begin errors++; $display("FAIL fips256 latency: got %0d expected 53", n); end
    checks++;
    if (ks8[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
      errors++; $display("FAIL fips256 k_sch14: got %h expected fe4890d1e6188d0b046df344706c631e", ks8[14]);
    end
    compute_model(k, 8);
    check_schedule(8, "fips256_model");
  endtask

  task automatic test_random_keys();
    int n;
    logic [255:0] k;
    for (int rep = 0; rep < 3; rep++) begin
      for (int nk = 4; nk <= 8; nk += 2) begin
        k = rand_key();
        load(nk, k);
        wait_ready(nk, n);
        checks++;
        if (n != 4 * (nk + 7) - nk + 1) begin
          errors++; $display("FAIL random latency nk=%0d: got %0d expected %0d", nk, n, 4*(nk+7)-nk+1);
        end
        compute_model(k, nk);
        check_schedule(nk, "random");
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic seen;
    logic [255:0] ka;
    logic [255:0] kb;
    ka = rand_key();
    kb = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    load(4, ka);
    seen = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (ready4 !== 1'b0) seen = 1'b1;
      tick();
    end
    if (ready4 !== 1'b0) seen = 1'b1;
    load(4, kb);
    wait_ready(4, n);
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL restart ready early: got 1 expected 0"); end
    checks++;
    if (n != 41) begin errors++; $display("FAIL restart latency: got %0d expected 41", n); end
    compute_model(kb, 4);
    check_schedule(4, "restart");
  endtask

  task automatic test_reset_mid();
    logic nz;
    logic seen;
    load(4, rand_key());
    for (int c = 0; c < 19; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nz = 1'b0;
    for (int r = 0; r <= 10; r++) if (ks4[r] !== 128'h0) nz = 1'b1;
    checks++;
    if (busy4 !== 1'b0 || ready4 !== 1'b0 || nz !== 1'b0) begin
      errors++; $display("FAIL reset_mid: busy=%b ready=%b nonzero=%b expected 0 0 0", busy4, ready4, nz);
    end
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (ready4 !== 1'b0 || busy4 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid idle: got activity expected none"); end
  endtask

  task automatic test_rst_and_load();
    int n;
    logic [255:0] k1;
    logic [255:0] k2;
    rst = 1'b1;
    load(4, rand_key());
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (busy4 !== 1'b0 || ready4 !== 1'b0 || ks4[0] !== 128'h0) begin
      errors++; $display("FAIL rst_and_load: busy=%b ready=%b k_sch0=%h expected 0 0 0", busy4, ready4, ks4[0]);
    end
    k1 = rand_key();
    load(4, k1);
    wait_ready(4, n);
    checks++;
    if (n != 41) begin errors++; $display("FAIL done_reload first latency: got %0d expected 41", n); end
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (ready4 !== 1'b1 || ks4[0] !== k1[127:0]) begin
      errors++; $display("FAIL done hold: ready=%b k_sch0=%h expected 1 %h", ready4, ks4[0], k1[127:0]);
    end
    k2 = rand_key();
    load(4, k2);
    checks++;
    if (ready4 !== 1'b0 || ks4[0] !== k2[127:0]) begin
      errors++; $display("FAIL done_reload edge: ready=%b k_sch0=%h expected 0 %h", ready4, ks4[0], k2[127:0]);
    end
    wait_ready(4, n);
    checks++;
    if (n != 41) begin errors++; $display("FAIL done_reload latency: got %0d expected 41", n); end
    compute_model(k2, 4);
    check_schedule(4, "done_reload");
  endtask

  initial begin
    rst = 1'b0;
    ld4 = 1'b0; ld6 = 1'b0; ld8 = 1'b0;
    key4 = 128'h0; key6 = 192'h0; key8 = 256'h0;
    build_sbox();
    test_reset();
    test_fips_vectors();
    test_random_keys();
    test_back_to_back();
    test_reset_mid();
    test_rst_and_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
